// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DP_WR,
      ST_DP_RD,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

endpackage

// File: rtl/ahb_be_decode.sv
// Byte-lane enables and alignment/size error from HSIZE and the low address bits.
module ahb_be_decode
   import ahb_pkg::*;
(
   input  logic [2:0] i_hsize,
   input  logic [1:0] i_addr_lo,
   output logic [3:0] o_be,
   output logic       o_err
);

   always_comb begin
      o_be  = 4'b1111;
      o_err = 1'b0;
      case (i_hsize)
         HSIZE_BYTE: o_be = 4'b0001 << i_addr_lo;
         HSIZE_HALF: begin
            o_be  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_err = i_addr_lo[0];
         end
         HSIZE_WORD: o_err = |i_addr_lo;
         default:    o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave onto a 1-cycle-latency single-port SRAM with wait states.
// AHB_SRAM_ERRRESP_EN: give ERROR on bad size/alignment; else do a word access.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA,
   output logic              sram_cs,
   output logic              sram_we,
   output logic [3:0]        sram_be,
   output logic [ADDR_W-3:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   slv_state_e        r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-3:0] r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_rdata;

   logic [3:0] w_dec_be;
   logic [3:0] w_be;
   logic       w_dec_err;
   logic       w_err;
   logic       w_accept;
   logic       w_wr_fire;
   logic       w_rd_issue;
   logic       w_rd_cap;
   logic       w_rd_last;
   logic       w_unused_bits;

   ahb_be_decode u_be_decode (
      .i_hsize   (HSIZE),
      .i_addr_lo (HADDR[1:0]),
      .o_be      (w_dec_be),
      .o_err     (w_dec_err)
   );

`ifdef AHB_SRAM_ERRRESP_EN
   assign w_err = w_dec_err;
   assign w_be  = w_dec_be;
`else
   assign w_err = 1'b0;
   assign w_be  = w_dec_err ? 4'b1111 : w_dec_be;
`endif

   assign w_unused_bits = ^{HADDR[31:ADDR_W], HTRANS[0]};

   assign w_wr_fire  = (r_state == ST_DP_WR) && (r_cnt == WS);
   assign w_rd_issue = (r_state == ST_DP_RD) && (r_cnt == 4'd0);
   assign w_rd_cap   = (r_state == ST_DP_RD) && (r_cnt == 4'd1);
   assign w_rd_last  = (r_state == ST_DP_RD) && (r_cnt == WS + 4'd1);

   assign HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_wr_fire || w_rd_last;
   assign HRESP     = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
   // Read data bypasses the capture register on the cycle it arrives.
   assign HRDATA    = w_rd_cap ? sram_rdata : r_rdata;

   assign w_accept = HREADYOUT & HSEL & HTRANS[1] & HREADY;

   assign sram_cs    = w_wr_fire | w_rd_issue;
   assign sram_we    = w_wr_fire;
   assign sram_be    = r_be;
   assign sram_addr  = r_addr;
   assign sram_wdata = HWDATA;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_be    <= '0;
         r_rdata <= '0;
      end else begin
         if (w_rd_cap) r_rdata <= sram_rdata;
         // Any ready cycle can take the next address phase with no bubble.
         if (HREADYOUT) begin
            r_cnt <= '0;
            if (w_accept) begin
               r_addr <= HADDR[ADDR_W-1:2];
               r_be   <= w_be;
               if (w_err)       r_state <= ST_ERR1;
               else if (HWRITE) r_state <= ST_DP_WR;
               else             r_state <= ST_DP_RD;
            end else begin
               r_state <= ST_IDLE;
            end
         end else if (r_state == ST_ERR1) begin
            r_state <= ST_ERR2;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: driver pushes expected responses, negedge monitor pops and compares.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   localparam int ADDR_W = 12;
   localparam int WS     = 2;
   localparam int DEPTH  = 1 << (ADDR_W - 2);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              HSEL   = 1'b0;
   logic [31:0]       HADDR  = '0;
   logic [1:0]        HTRANS = '0;
   logic              HWRITE = 1'b0;
   logic [2:0]        HSIZE  = '0;
   logic [31:0]       HWDATA = '0;
   logic              HREADY, HREADYOUT, HRESP;
   logic [31:0]       HRDATA;
   logic              sram_cs, sram_we;
   logic [3:0]        sram_be;
   logic [ADDR_W-3:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;

   assign HREADY = HREADYOUT;

   ahb_sram_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
      .clk_i(clk), .rst_i(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   logic [31:0] sram_mem [DEPTH];
   logic [31:0] ref_mem  [DEPTH];

   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   typedef struct {
      bit                err;
      bit                wr;
      logic [3:0]        be;
      logic [ADDR_W-3:0] addr;
      logic [31:0]       data;
      int                cyc;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: expected response computed from the size/alignment rules on a word array.
   task automatic issue(input bit sel, input logic [1:0] tr, input bit wr,
                        input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      exp_t       e;
      logic [3:0] be;
      bit         bad;
      bit         ok;
      int         wi;
      HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz;
      if (mon_en && sel && tr[1]) begin
         wi  = int'(a[ADDR_W-1:2]);
         bad = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
         case (sz)
            3'd0:    be = 4'b0001 << a[1:0];
            3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
         endcase
         e.err = 1'b0;
`ifdef AHB_SRAM_ERRRESP_EN
         e.err = bad;
`else
         if (bad) be = 4'b1111;
`endif
         e.wr   = wr;
         e.be   = be;
         e.addr = a[ADDR_W-1:2];
         if (wr) begin
            e.data = wd;
            if (!e.err)
               for (int b = 0; b < 4; b++)
                  if (be[b]) ref_mem[wi][8*b +: 8] = wd[8*b +: 8];
         end else begin
            e.data = ref_mem[wi];
         end
         e.cyc = e.err ? 2 : (wr ? WS + 1 : WS + 2);
         q.push_back(e);
      end
      ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         ok = HREADYOUT;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: HREADYOUT stayed 0, required 1");
      end
      HWDATA = wd;
   endtask

   exp_t              cur;
   bit                in_dp = 1'b0;
   int                cyc, ncs, nwe;
   logic [3:0]        s_be;
   logic [ADDR_W-3:0] s_addr;
   logic [31:0]       s_wd;

   always @(negedge clk) begin
      if (rst || !mon_en) begin
         in_dp = 1'b0;
      end else begin
         if (in_dp) begin
            cyc++;
            chk("hresp", {31'd0, HRESP}, {31'd0, cur.err});
            if (sram_cs) begin
               ncs++;
               s_addr = sram_addr;
               if (sram_we) begin
                  nwe++;
                  s_be = sram_be;
                  s_wd = sram_wdata;
               end
            end
            if (HREADYOUT) begin
               chk("dp_cycles", cyc, cur.cyc);
               chk("sram_cs_count", ncs, cur.err ? 0 : 1);
               chk("sram_we_count", nwe, (!cur.err && cur.wr) ? 1 : 0);
               if (!cur.err) chk("sram_addr", {22'd0, s_addr}, {22'd0, cur.addr});
               if (!cur.err && cur.wr) begin
                  chk("sram_be", {28'd0, s_be}, {28'd0, cur.be});
                  chk("sram_wdata", s_wd, cur.data);
               end
               if (!cur.err && !cur.wr) chk("hrdata", HRDATA, cur.data);
               in_dp = 1'b0;
            end
         end else begin
            chk("idle_hreadyout", {31'd0, HREADYOUT}, 32'd1);
            chk("idle_hresp", {31'd0, HRESP}, 32'd0);
            chk("idle_sram_cs", {31'd0, sram_cs}, 32'd0);
         end
         if (HSEL && HTRANS[1] && HREADY) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_empty: accepted transfer with no expected entry");
            end else begin
               cur   = q.pop_front();
               in_dp = 1'b1;
               cyc   = 0;
               ncs   = 0;
               nwe   = 0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         sram_mem[i] = v;
         ref_mem[i]  = v;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      chk("reset_hresp", {31'd0, HRESP}, 32'd0);
      chk("reset_hrdata", HRDATA, 32'd0);
      chk("reset_sram_cs", {31'd0, sram_cs}, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back write/read, byte merge, misaligned half, non-transfers, wrap.
      issue(1, HTRANS_NONSEQ, 1, 32'h010, HSIZE_WORD, 32'hDEADBEEF);
      issue(1, HTRANS_NONSEQ, 0, 32'h010, HSIZE_WORD, 32'h0);
      issue(1, HTRANS_NONSEQ, 1, 32'h010, HSIZE_WORD, 32'h11223344);
      issue(1, HTRANS_NONSEQ, 1, 32'h013, HSIZE_BYTE, 32'hAA000000);
      issue(1, HTRANS_NONSEQ, 0, 32'h010, HSIZE_WORD, 32'h0);
      issue(1, HTRANS_NONSEQ, 0, 32'h001, HSIZE_HALF, 32'h0);
      issue(1, HTRANS_IDLE,   0, 32'h010, HSIZE_WORD, 32'h0);
      issue(0, HTRANS_NONSEQ, 1, 32'h010, HSIZE_WORD, 32'h55AA55AA);
      issue(1, HTRANS_BUSY,   1, 32'h010, HSIZE_WORD, 32'h0);
      issue(1, HTRANS_NONSEQ, 1, 32'h1014, HSIZE_WORD, 32'hCAFEF00D);
      issue(1, HTRANS_NONSEQ, 0, 32'h014, HSIZE_WORD, 32'h0);
      issue(1, HTRANS_NONSEQ, 1, 32'h016, HSIZE_HALF, 32'h9876ABCD);
      issue(1, HTRANS_NONSEQ, 0, 32'h014, HSIZE_WORD, 32'h0);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         logic [1:0]  tr;
         bit          sel, wr;
         a  = $urandom_range(0, 63);
         sz = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            if (sz == 3'd2) a[1:0] = 2'b00;
            else if (sz == 3'd1) a[0] = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
         tr  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : HTRANS_NONSEQ;
         sel = ($urandom_range(0, 7) != 0);
         wr  = 1'($urandom_range(0, 1));
         issue(sel, tr, wr, a, sz, $urandom);
      end
      issue(0, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 32'd0);

      // Reset while a read is waiting.
      mon_en = 1'b0;
      issue(1, HTRANS_NONSEQ, 0, 32'h010, HSIZE_WORD, 32'h0);
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_hreadyout", {31'd0, HREADYOUT}, 32'd0);
      chk("pre_rst_hrdata", HRDATA, ref_mem[4]);
      rst = 1'b1;
      #1;
      chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      chk("rst_hresp", {31'd0, HRESP}, 32'd0);
      chk("rst_sram_cs", {31'd0, sram_cs}, 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset before the write cycle must leave memory untouched.
      issue(1, HTRANS_NONSEQ, 1, 32'h020, HSIZE_WORD, 32'h55555555);
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_no_write", sram_mem[8], ref_mem[8]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave on the Ibex-side bus, directly downstream of the Ibex-to-AHB bridge.
- Accepts the single NONSEQ transfers the bridge issues and maps them onto a synchronous single-port SRAM with 1-cycle read latency.
- Generates HREADYOUT wait states, byte-lane enables from HSIZE/HADDR, and the two-cycle AHB ERROR response.

Parameters:
- ADDR_W, 12, byte-address bits decoded (SRAM depth = 2^(ADDR_W-2) words)
- WAIT_STATES, 0, extra wait cycles added to every data phase (0..7)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  32  address (only [ADDR_W-1:0] used)
- HTRANS  in  2  transfer type
- HWRITE  in  1  write not read
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready (previous transfer completing)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_be  out  4  SRAM byte enables
- sram_addr  out  ADDR_W-2  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after a read with sram_cs=1

Behaviour:
- Reset (async, immediate): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, sram_cs=0, sram_we=0, cnt=0, address-phase registers cleared. A reset mid-transfer abandons it; no SRAM write is issued.
- Accept condition: HSEL & HTRANS[1] & HREADY.
  - On accept, register word address, HWRITE, byte enables and the error flag.
  - IDLE/BUSY transfers and unselected cycles get a zero-wait OKAY and no SRAM access.
- Byte enables:
  - HSIZE=000: 1<<HADDR[1:0]
  - HSIZE=001: HADDR[1] ? 1100 : 0011
  - HSIZE=010: 1111
- Error flag is set for any of: HSIZE>010; halfword with HADDR[0]=1; word with HADDR[1:0]!=0.
- Addresses above the SRAM depth wrap modulo 2^ADDR_W.
- States: IDLE, DP_WR, DP_RD, ERR1, ERR2. cnt counts data-phase cycles, starting at 0.
- IDLE: HREADYOUT=1, HRESP=0. On accept, go to ERR1 if error, else DP_WR or DP_RD.
- DP_WR:
  - HREADYOUT=0 while cnt<WAIT_STATES.
  - At cnt==WAIT_STATES: HREADYOUT=1; sram_cs=1, sram_we=1, sram_be=reg be, sram_wdata=HWDATA. Exactly one SRAM write per transfer.
  - Data-phase length = WAIT_STATES+1 cycles.
- DP_RD:
  - At cnt==0: sram_cs=1, sram_we=0.
  - At cnt==1: capture sram_rdata into rdata_q.
  - HREADYOUT=1 at cnt==WAIT_STATES+1, so the minimum is 1 wait state.
  - HRDATA = sram_rdata when cnt==1, else rdata_q. HRDATA holds its value until the next read completes.
- ERR1: HREADYOUT=0, HRESP=1, no SRAM access. Go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1.
- Pipelining: in any cycle with HREADYOUT=1 (IDLE, final DP cycle, ERR2), a new address phase may be accepted. The next state is entered directly with cnt=0, with no idle bubble.
- Write followed by read of the same address: the write commits in the last write data-phase cycle, and the read issues in the next cycle, so the new data is returned. No forwarding is needed.
- A master dropping HSEL during a wait state has no effect; the transfer completes.

Optional Feature:
- Macro AHB_SRAM_ERRRESP_EN.
- Defined: behaviour as above (ERROR response for unsupported or misaligned transfers).
- Undefined: the error flag is ignored. Unsupported or misaligned transfers are performed as OKAY word accesses to HADDR[ADDR_W-1:2] with be=1111, with normal DP_WR/DP_RD timing. ERR1/ERR2 are unreachable and may be removed.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE codes (BYTE/HALF/WORD)
  - HRESP codes (OKAY/ERROR)
  - slave state encoding
- One natural sub-module: ahb_be_decode. It is combinational; inputs HSIZE and HADDR[1:0], outputs be[3:0] and err. It is reusable by future AHB slaves (peripheral bridge, GPIO).

Test Plan:
- Reset during a DP_RD wait state (WAIT_STATES=2) -> HREADYOUT=1, HRESP=0, sram_cs=0 in the same cycle; HRDATA=0.
- WAIT_STATES=0: word write 0xDEADBEEF to 0x010, then word read of 0x010 back-to-back -> write data phase 1 cycle with sram_be=1111; read data phase 2 cycles; HRDATA=0xDEADBEEF.
- Byte write 0xAA at 0x013 over an existing 0x11223344 -> sram_be=1000; a later word read returns 0xAA223344.
- WAIT_STATES=3: word read -> HREADYOUT low for exactly 4 cycles, then high with correct data; a pipelined next address phase is accepted in the same cycle.
- Halfword read at 0x001 with AHB_SRAM_ERRRESP_EN -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), no sram_cs. Without the macro -> OKAY word read of address 0x000.
- HTRANS=IDLE with HSEL=1, and NONSEQ with HSEL=0 -> zero-wait OKAY, sram_cs never asserted.
